// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch-stage next-PC generator and its BTB.
package fetch_pkg;

  localparam int PC_W = 16;

  typedef logic [PC_W-1:0] pc_t;

  localparam pc_t RESET_PC_DEFAULT = 16'h0000;
  localparam int  FETCH_BTB_IDX_W  = 6;

  // Tag is kept right-aligned in a full pc_t so the entry layout does not
  // depend on the BTB index width chosen by the instantiating module.
  typedef struct packed {
    pc_t tag;
    pc_t target;
  } btb_entry_t;

  // Source of the next fetch PC, in decreasing priority order.
  typedef enum logic [1:0] {
    NPC_REDIRECT,
    NPC_HOLD,
    NPC_PRED,
    NPC_SEQ
  } npc_sel_e;

  function automatic pc_t btb_tag(input pc_t pc, input int unsigned idx_w);
    return pc >> idx_w;
  endfunction

endpackage

// File: rtl/btb_ram.sv
// Direct-mapped BTB storage: sync-read tag/target array and a resettable valid vector.
// FETCH_BTB_FWD_EN selects write-to-read forwarding; otherwise reads return the old entry.
module btb_ram
  import fetch_pkg::*;
#(
  parameter int IDX_W = FETCH_BTB_IDX_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rd_en_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_valid_o,
  output btb_entry_t       rd_entry_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  btb_entry_t       wr_entry_i
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [DEPTH-1:0] valid_q;
  btb_entry_t       mem_q [DEPTH];

  logic             rd_valid_d;
  logic             rd_valid_q;
  btb_entry_t       rd_entry_d;
  btb_entry_t       rd_entry_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // NOTE: the tag/target array has no reset; the valid vector alone decides
  // whether an entry means anything, so clearing the storage would buy nothing.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_entry_i;
    end
  end

`ifdef FETCH_BTB_FWD_EN
  logic fwd;

  always_comb begin
    fwd        = wr_en_i && (wr_idx_i == rd_idx_i);
    rd_valid_d = fwd ? 1'b1 : valid_q[rd_idx_i];
    rd_entry_d = fwd ? wr_entry_i : mem_q[rd_idx_i];
  end
`else
  always_comb begin
    rd_valid_d = valid_q[rd_idx_i];
    rd_entry_d = mem_q[rd_idx_i];
  end
`endif

  // The read register holds while the pipeline is stalled so it stays aligned with pc_ID.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_valid_q <= 1'b0;
    end else if (rd_en_i) begin
      rd_valid_q <= rd_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      rd_entry_q <= rd_entry_d;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_entry_o = rd_entry_q;

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-stage next-PC generator: pc_IF/pc_ID registers, BTB lookup, redirect priority and flushes.
// Build option FETCH_BTB_FWD_EN enables same-cycle BTB write forwarding inside btb_ram.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int  BTB_IDX_W = FETCH_BTB_IDX_W,
  parameter pc_t RESET_PC  = RESET_PC_DEFAULT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             stall,
  output logic [PC_W-1:0]  pc_IF,
  output logic [PC_W-1:0]  pc_ID,
  input  logic             branch_predict_ID,
  output logic             pred_taken_ID,
  output logic [PC_W-1:0]  pred_target_ID,
  output logic             btb_hit_ID,
  output logic             flush_IF,
  output logic             flush_ID,
  input  logic             branch_EX,
  input  logic             branch_result_EX,
  input  logic [PC_W-1:0]  pc_EX,
  input  logic [PC_W-1:0]  target_EX,
  input  logic             redirect_EX,
  input  logic [PC_W-1:0]  redirect_pc_EX
);

  pc_t        pc_if_q;
  pc_t        pc_if_d;
  pc_t        pc_id_q;
  logic       valid_id_q;

  npc_sel_e   npc_sel;
  logic       advance;
  logic       btb_hit;
  logic       pred_taken;
  logic       flush_if;
  logic       flush_id;

  logic       rd_valid;
  btb_entry_t rd_entry;
  logic       wr_en;
  btb_entry_t wr_entry;

  // A redirect from EX must move the front end even when ID is stalled.
  assign advance = !stall || redirect_EX;

  assign wr_en           = branch_EX && branch_result_EX;
  assign wr_entry.tag    = btb_tag(pc_EX, BTB_IDX_W);
  assign wr_entry.target = target_EX;

  btb_ram #(
    .IDX_W (BTB_IDX_W)
  ) u_btb_ram (
    .clk        (clk),
    .rstn       (rstn),
    .rd_en_i    (advance),
    .rd_idx_i   (pc_if_q[BTB_IDX_W-1:0]),
    .rd_valid_o (rd_valid),
    .rd_entry_o (rd_entry),
    .wr_en_i    (wr_en),
    .wr_idx_i   (pc_EX[BTB_IDX_W-1:0]),
    .wr_entry_i (wr_entry)
  );

  assign btb_hit    = valid_id_q && rd_valid &&
                      (rd_entry.tag == btb_tag(pc_id_q, BTB_IDX_W));
  assign pred_taken = btb_hit && branch_predict_ID;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave a value unassigned and infer a latch.
  always_comb begin
    npc_sel  = NPC_SEQ;
    flush_if = 1'b0;
    flush_id = 1'b0;
    if (redirect_EX) begin
      npc_sel  = NPC_REDIRECT;
      flush_if = 1'b1;
      flush_id = 1'b1;
    end else if (stall) begin
      npc_sel  = NPC_HOLD;
    end else if (pred_taken) begin
      npc_sel  = NPC_PRED;
      flush_if = 1'b1;
    end
  end

  always_comb begin
    pc_if_d = pc_if_q + pc_t'(1);
    unique case (npc_sel)
      NPC_REDIRECT: pc_if_d = redirect_pc_EX;
      NPC_HOLD:     pc_if_d = pc_if_q;
      NPC_PRED:     pc_if_d = rd_entry.target;
      NPC_SEQ:      pc_if_d = pc_if_q + pc_t'(1);
      default:      pc_if_d = pc_if_q + pc_t'(1);
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_if_q <= RESET_PC;
    end else begin
      pc_if_q <= pc_if_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_id_q    <= '0;
      valid_id_q <= 1'b0;
    end else if (advance) begin
      pc_id_q    <= pc_if_q;
      valid_id_q <= !flush_if;
    end
  end

  assign pc_IF          = pc_if_q;
  assign pc_ID          = pc_id_q;
  assign pred_taken_ID  = pred_taken;
  assign pred_target_ID = rd_entry.target;
  assign btb_hit_ID     = btb_hit;
  assign flush_IF       = flush_if;
  assign flush_ID       = flush_id;

endmodule
